// File: rtl/calc_pkg.sv
// Package for the calculator sequencer slice.
// Holds the keypad code map, the FSM state encoding, the default operand
// ceiling and the carry_in selection helper shared by the sequencer.
package calc_pkg;

  // Keypad codes: 0-9 are digits, A-E are operators, F is equals.
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_AND = 4'hC;
  localparam logic [3:0] KEY_OR  = 4'hD;
  localparam logic [3:0] KEY_CMP = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

  // ALU op select value that leaves the ALU idle.
  localparam logic [3:0] ALU_IDLE = 4'h0;

  // Largest operand accepted by decimal entry.
  localparam int MAX_VAL_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_OPA    = 2'd0,  // entering operand A
    ST_OPB    = 2'd1,  // operator chosen, entering operand B
    ST_EXEC   = 2'd2,  // ALU inputs driven for exactly one cycle
    ST_RESULT = 2'd3   // result on display
  } state_t;

  // carry_in for the op about to be evaluated. Add/sub can chain the stored
  // carry/borrow from a previous evaluation of the same op; otherwise add
  // starts fresh with 0 and subtract with 1 (no borrow). Compare is a plain
  // subtract, so it always gets 1.
  function automatic logic calc_carry_in(input logic [3:0] op,
                                         input logic [3:0] prev_op,
                                         input logic       carry_reg,
                                         input logic       chain);
    logic cin;
    cin = 1'b0;
    case (op)
      KEY_ADD: cin = (chain && (prev_op == KEY_ADD)) ? carry_reg : 1'b0;
      KEY_SUB: cin = (chain && (prev_op == KEY_SUB)) ? carry_reg : 1'b1;
      KEY_CMP: cin = 1'b1;
      default: cin = 1'b0;
    endcase
    return cin;
  endfunction

endpackage

// File: rtl/calc_ctrl_if.sv
// ALU bus between the calculator sequencer and the ALU.
//   cs        op select (0 = idle)      a, b     8-bit operands
//   carry_in  ALU carry input           s        8-bit ALU result
//   zero      ALU zero flag             carry_out ALU carry (add: carry,
//                                        sub: 1 = no borrow, cmp: 1 = a<b)
// The sequencer is the master: it drives op/operands, the ALU answers
// combinationally in the same cycle.
interface calc_ctrl_if;
  logic [3:0] cs;
  logic [7:0] a;
  logic [7:0] b;
  logic       carry_in;
  logic [7:0] s;
  logic       zero;
  logic       carry_out;

  modport master (
    output cs, a, b, carry_in,
    input  s, zero, carry_out
  );

  modport slave (
    input  cs, a, b, carry_in,
    output s, zero, carry_out
  );
endinterface

// File: rtl/calc_dec_entry.sv
// Decimal digit entry: val_next = val*10 + digit, computed wide so that the
// overflow test against MAX_VAL is exact.
//   val       in  8  current operand value
//   digit     in  4  new digit 0-9
//   val_next  out 8  accumulated value (only meaningful when !overflow)
//   overflow  out 1  val*10+digit exceeds MAX_VAL
module calc_dec_entry #(
  parameter int MAX_VAL = 255
) (
  input  logic [7:0] val,
  input  logic [3:0] digit,
  output logic [7:0] val_next,
  output logic       overflow
);

  logic [11:0] wide;

  // 255*10+9 = 2559 fits in 12 bits.
  assign wide     = ({4'b0, val} * 12'd10) + {8'b0, digit};
  assign overflow = (wide > 12'(MAX_VAL));
  assign val_next = wide[7:0];

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencer: turns keypad codes into two decimal operands and an
// operator, drives the ALU for exactly one cycle per evaluation, captures the
// ALU result/flags and presents them to the display path.
//   IN_clk, IN_rst_n        clock, synchronous active-low reset
//   IN_key_valid/code       one-cycle key strobe + code (0-9, A-E ops, F =)
//   alu                     ALU bus (master side)
//   OUT_disp_value          A in OPA, B in OPB, result in EXEC/RESULT
//   OUT_disp_op             pending operator while in OPB/EXEC, else 0
//   OUT_flag_carry/zero     flags of the last result
//   OUT_result_valid        one-cycle pulse when a new result is shown
//   OUT_busy                high in EXEC; keys are ignored then
//   OUT_err                 one-cycle pulse on a rejected key
//   OUT_dbg_state           current FSM state
// Handshake: a key is accepted whenever IN_key_valid is high on a rising
// edge and the sequencer is not busy; there is no back-pressure, so a key
// strobed while busy is silently lost.
// Key timing: keys are registered once before the FSM acts on them, so an F
// sampled at edge t drives the ALU during the cycle after edge t+1 and the
// result is captured at edge t+2.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter bit CHAIN_CARRY = 1'b1,
  parameter int MAX_VAL     = MAX_VAL_DEFAULT
) (
  input  logic        IN_clk,
  input  logic        IN_rst_n,
  input  logic        IN_key_valid,
  input  logic [3:0]  IN_key_code,
  calc_ctrl_if.master alu,
  output logic [7:0]  OUT_disp_value,
  output logic [3:0]  OUT_disp_op,
  output logic        OUT_flag_carry,
  output logic        OUT_flag_zero,
  output logic        OUT_result_valid,
  output logic        OUT_busy,
  output logic        OUT_err,
  output logic [1:0]  OUT_dbg_state
);

  state_t     state_q, state_d;

  logic       key_valid_q;
  logic [3:0] key_code_q;

  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] result_q;
  logic [3:0] op_q, op_d;
  logic [3:0] prev_op_q;
  logic       b_entered_q, b_entered_d;
  // Carry of the last result; doubles as the chained carry/borrow source.
  logic       flag_carry_q;
  logic       flag_zero_q;
  logic       result_valid_q;
  logic       err_q, err_d;
  logic       go_exec;
  logic       cin_d;

  logic [3:0] alu_cs_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic       alu_cin_q;

  logic       is_digit;
  logic       is_op;
  logic       is_eq;
  logic [7:0] entry_val;
  logic [7:0] entry_next;
  logic       entry_ovf;

  // Single entry datapath, fed from whichever operand is being typed.
  assign entry_val = (state_q == ST_OPB) ? b_q : a_q;

  calc_dec_entry #(
    .MAX_VAL (MAX_VAL)
  ) u_entry (
    .val      (entry_val),
    .digit    (key_code_q),
    .val_next (entry_next),
    .overflow (entry_ovf)
  );

  assign is_digit = (key_code_q <= KEY_DIGIT_MAX);
  assign is_op    = (key_code_q >= KEY_ADD) && (key_code_q <= KEY_CMP);
  assign is_eq    = (key_code_q == KEY_EQ);

  // Key capture; keys arriving while busy are dropped here.
  always_ff @(posedge IN_clk) begin
    if (!IN_rst_n) begin
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      key_valid_q <= IN_key_valid && (state_q != ST_EXEC);
      key_code_q  <= IN_key_code;
    end
  end

  // Next-state and operand update logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    b_entered_d = b_entered_q;
    go_exec     = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_OPA: begin
        if (key_valid_q) begin
          if (is_digit) begin
            if (entry_ovf) err_d = 1'b1;
            else           a_d   = entry_next;
          end else if (is_op) begin
            op_d        = key_code_q;
            b_d         = 8'd0;
            b_entered_d = 1'b0;
            state_d     = ST_OPB;
          end
        end
      end
      ST_OPB: begin
        if (key_valid_q) begin
          if (is_digit) begin
            if (entry_ovf) begin
              err_d = 1'b1;
            end else begin
              b_d         = entry_next;
              b_entered_d = 1'b1;
            end
          end else if (is_op) begin
            // The operator may only be changed before B is typed.
            if (b_entered_q) err_d = 1'b1;
            else             op_d  = key_code_q;
          end else if (is_eq) begin
            go_exec = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_RESULT;
      end
      ST_RESULT: begin
        if (key_valid_q) begin
          if (is_digit) begin
            a_d     = {4'h0, key_code_q};
            state_d = ST_OPA;
          end else if (is_op) begin
            a_d         = result_q;
            op_d        = key_code_q;
            b_d         = 8'd0;
            b_entered_d = 1'b0;
            state_d     = ST_OPB;
          end else if (is_eq) begin
            // Repeat: the result becomes A, B and the operator are kept.
            a_d     = result_q;
            go_exec = 1'b1;
          end
        end
      end
    endcase

    if (go_exec) state_d = ST_EXEC;
  end

  assign cin_d = calc_carry_in(op_d, prev_op_q, flag_carry_q, CHAIN_CARRY);

  always_ff @(posedge IN_clk) begin
    if (!IN_rst_n) begin
      state_q        <= ST_OPA;
      a_q            <= 8'd0;
      b_q            <= 8'd0;
      result_q       <= 8'd0;
      op_q           <= 4'h0;
      prev_op_q      <= 4'h0;
      b_entered_q    <= 1'b0;
      flag_carry_q   <= 1'b0;
      flag_zero_q    <= 1'b0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      alu_cs_q       <= ALU_IDLE;
      alu_a_q        <= 8'd0;
      alu_b_q        <= 8'd0;
      alu_cin_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      b_entered_q    <= b_entered_d;
      err_q          <= err_d;
      result_valid_q <= (state_q == ST_EXEC);

      // ALU drive registers hold values only for the EXEC cycle.
      if (go_exec) begin
        alu_cs_q  <= op_d;
        alu_a_q   <= a_d;
        alu_b_q   <= b_d;
        alu_cin_q <= cin_d;
      end else begin
        alu_cs_q  <= ALU_IDLE;
        alu_a_q   <= 8'd0;
        alu_b_q   <= 8'd0;
        alu_cin_q <= 1'b0;
      end

      if (state_q == ST_EXEC) begin
        result_q     <= alu.s;
        flag_zero_q  <= alu.zero;
        flag_carry_q <= alu.carry_out;
        prev_op_q    <= op_q;
      end
    end
  end

  assign alu.cs       = alu_cs_q;
  assign alu.a        = alu_a_q;
  assign alu.b        = alu_b_q;
  assign alu.carry_in = alu_cin_q;

  always_comb begin
    OUT_disp_value = 8'd0;
    OUT_disp_op    = 4'h0;
    case (state_q)
      ST_OPA:    OUT_disp_value = a_q;
      ST_OPB:    begin OUT_disp_value = b_q;      OUT_disp_op = op_q; end
      ST_EXEC:   begin OUT_disp_value = result_q; OUT_disp_op = op_q; end
      ST_RESULT: OUT_disp_value = result_q;
    endcase
  end

  assign OUT_flag_carry   = flag_carry_q;
  assign OUT_flag_zero    = flag_zero_q;
  assign OUT_result_valid = result_valid_q;
  assign OUT_busy         = (state_q == ST_EXEC);
  assign OUT_err          = err_q;
  assign OUT_dbg_state    = state_q;

endmodule

// File: tb/tb_calc_ctrl.sv
module tb_calc_ctrl;
  import calc_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] disp_value;
  logic [3:0] disp_op;
  logic       flag_carry;
  logic       flag_zero;
  logic       result_valid;
  logic       busy;
  logic       err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  calc_ctrl_if alu_if ();

  calc_ctrl #(
    .CHAIN_CARRY (1'b1),
    .MAX_VAL     (255)
  ) dut (
    .IN_clk           (clk),
    .IN_rst_n         (rst_n),
    .IN_key_valid     (key_valid),
    .IN_key_code      (key_code),
    .alu              (alu_if.master),
    .OUT_disp_value   (disp_value),
    .OUT_disp_op      (disp_op),
    .OUT_flag_carry   (flag_carry),
    .OUT_flag_zero    (flag_zero),
    .OUT_result_valid (result_valid),
    .OUT_busy         (busy),
    .OUT_err          (err),
    .OUT_dbg_state    (dbg_state)
  );

  // Behavioural ALU alongside the sequencer.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum          = 9'd0;
    alu_if.s         = 8'd0;
    alu_if.carry_out = 1'b0;
    case (alu_if.cs)
      4'hA: begin
        alu_sum          = {1'b0, alu_if.a} + {1'b0, alu_if.b} + {8'd0, alu_if.carry_in};
        alu_if.s         = alu_sum[7:0];
        alu_if.carry_out = alu_sum[8];
      end
      4'hB: begin
        alu_sum          = {1'b0, alu_if.a} + {1'b0, ~alu_if.b} + {8'd0, alu_if.carry_in};
        alu_if.s         = alu_sum[7:0];
        alu_if.carry_out = alu_sum[8];
      end
      4'hC: alu_if.s = alu_if.a & alu_if.b;
      4'hD: alu_if.s = alu_if.a | alu_if.b;
      4'hE: begin
        alu_sum          = {1'b0, alu_if.a} + {1'b0, ~alu_if.b} + {8'd0, alu_if.carry_in};
        alu_if.s         = alu_sum[7:0];
        alu_if.carry_out = (alu_if.a < alu_if.b);
      end
      default: ;
    endcase
    alu_if.zero = (alu_if.s == 8'd0);
  end

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Strobe one key; returns at the negedge where its effect is visible.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    key_valid = 1'b1;
    key_code  = 4'h7;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (disp_value !== 8'd0) begin
      n_fail++; $display("FAIL reset_disp: got %0d want 0", disp_value);
    end
    n_checks++;
    if ({disp_op, flag_carry, flag_zero, result_valid, busy, err} !== 9'd0) begin
      n_fail++; $display("FAIL reset_outs: got %b want 0", {disp_op, flag_carry, flag_zero, result_valid, busy, err});
    end
    n_checks++;
    if ({alu_if.cs, alu_if.a, alu_if.b, alu_if.carry_in} !== 21'd0) begin
      n_fail++; $display("FAIL reset_alu: got %h want 0", {alu_if.cs, alu_if.a, alu_if.b, alu_if.carry_in});
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
  endtask

  task automatic test_add();
    do_reset();
    press(4'd1); press(4'd2);
    n_checks++;
    if (disp_value !== 8'd12) begin
      n_fail++; $display("FAIL add_entry_a: got %0d want 12", disp_value);
    end
    press(4'hA);
    n_checks++;
    if (disp_op !== 4'hA || disp_value !== 8'd0) begin
      n_fail++; $display("FAIL add_op: got op %h disp %0d want op A disp 0", disp_op, disp_value);
    end
    press(4'd3); press(4'd4);
    n_checks++;
    if (disp_value !== 8'd34) begin
      n_fail++; $display("FAIL add_entry_b: got %0d want 34", disp_value);
    end
    press(4'hF);
    n_checks++;
    if (alu_if.cs !== 4'hA || alu_if.a !== 8'd12 || alu_if.b !== 8'd34 || alu_if.carry_in !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL add_exec: got cs %h a %0d b %0d cin %b busy %b want A 12 34 0 1",
                         alu_if.cs, alu_if.a, alu_if.b, alu_if.carry_in, busy);
    end
    @(negedge clk);
    n_checks++;
    if (disp_value !== 8'd46 || flag_zero !== 1'b0 || flag_carry !== 1'b0 || result_valid !== 1'b1) begin
      n_fail++; $display("FAIL add_result: got disp %0d z %b c %b v %b want 46 0 0 1",
                         disp_value, flag_zero, flag_carry, result_valid);
    end
    n_checks++;
    if (alu_if.cs !== 4'h0 || busy !== 1'b0 || dbg_state !== 2'd3) begin
      n_fail++; $display("FAIL add_idle: got cs %h busy %b state %0d want 0 0 3", alu_if.cs, busy, dbg_state);
    end
    @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_valid_pulse: got %b want 0", result_valid);
    end
    press(4'd7);
    n_checks++;
    if (dbg_state !== 2'd0 || disp_value !== 8'd7) begin
      n_fail++; $display("FAIL result_digit: got state %0d disp %0d want 0 7", dbg_state, disp_value);
    end
  endtask

  task automatic test_chain_sub();
    do_reset();
    press(4'd2); press(4'd0); press(4'd0); press(4'hA);
    press(4'd1); press(4'd0); press(4'd0); press(4'hF);
    @(negedge clk);
    n_checks++;
    if (disp_value !== 8'd44 || flag_carry !== 1'b1) begin
      n_fail++; $display("FAIL chain_first: got disp %0d c %b want 44 1", disp_value, flag_carry);
    end
    press(4'hF);
    n_checks++;
    if (alu_if.a !== 8'd44 || alu_if.b !== 8'd100 || alu_if.carry_in !== 1'b1) begin
      n_fail++; $display("FAIL chain_exec: got a %0d b %0d cin %b want 44 100 1", alu_if.a, alu_if.b, alu_if.carry_in);
    end
    @(negedge clk);
    n_checks++;
    if (disp_value !== 8'd145 || flag_carry !== 1'b0) begin
      n_fail++; $display("FAIL chain_repeat: got disp %0d c %b want 145 0", disp_value, flag_carry);
    end
    // Subtract starts fresh: previous op was add.
    press(4'd5); press(4'hB); press(4'd7); press(4'hF);
    n_checks++;
    if (alu_if.cs !== 4'hB || alu_if.carry_in !== 1'b1) begin
      n_fail++; $display("FAIL sub_exec: got cs %h cin %b want B 1", alu_if.cs, alu_if.carry_in);
    end
    @(negedge clk);
    n_checks++;
    if (disp_value !== 8'd254 || flag_carry !== 1'b0) begin
      n_fail++; $display("FAIL sub_borrow: got disp %0d c %b want 254 0", disp_value, flag_carry);
    end
    press(4'hF);
    n_checks++;
    if (alu_if.a !== 8'd254 || alu_if.b !== 8'd7 || alu_if.carry_in !== 1'b0) begin
      n_fail++; $display("FAIL sub_chain_exec: got a %0d b %0d cin %b want 254 7 0", alu_if.a, alu_if.b, alu_if.carry_in);
    end
    @(negedge clk);
    n_checks++;
    if (disp_value !== 8'd246 || flag_carry !== 1'b1) begin
      n_fail++; $display("FAIL sub_repeat: got disp %0d c %b want 246 1", disp_value, flag_carry);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    press(4'd2); press(4'd5); press(4'd5);
    n_checks++;
    if (disp_value !== 8'd255 || err !== 1'b0) begin
      n_fail++; $display("FAIL ovf_max: got disp %0d err %b want 255 0", disp_value, err);
    end
    press(4'd6);
    n_checks++;
    if (disp_value !== 8'd255 || err !== 1'b1) begin
      n_fail++; $display("FAIL ovf_reject: got disp %0d err %b want 255 1", disp_value, err);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL ovf_err_pulse: got %b want 0", err);
    end
  endtask

  task automatic test_cmp();
    do_reset();
    press(4'd9); press(4'hE); press(4'd9); press(4'hF);
    n_checks++;
    if (alu_if.cs !== 4'hE || alu_if.carry_in !== 1'b1) begin
      n_fail++; $display("FAIL cmp_exec: got cs %h cin %b want E 1", alu_if.cs, alu_if.carry_in);
    end
    @(negedge clk);
    n_checks++;
    if (flag_zero !== 1'b1 || flag_carry !== 1'b0 || alu_if.cs !== 4'h0) begin
      n_fail++; $display("FAIL cmp_result: got z %b c %b cs %h want 1 0 0", flag_zero, flag_carry, alu_if.cs);
    end
  endtask

  task automatic test_busy();
    do_reset();
    press(4'd1); press(4'hA); press(4'd2); press(4'hF);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_high: got %b want 1", busy);
    end
    key_valid = 1'b1;
    key_code  = 4'd5;
    @(negedge clk);
    key_valid = 1'b0;
    n_checks++;
    if (result_valid !== 1'b1 || disp_value !== 8'd3) begin
      n_fail++; $display("FAIL busy_result: got v %b disp %0d want 1 3", result_valid, disp_value);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (dbg_state !== 2'd3 || disp_value !== 8'd3 || err !== 1'b0) begin
      n_fail++; $display("FAIL busy_key_ignored: got state %0d disp %0d err %b want 3 3 0", dbg_state, disp_value, err);
    end
  endtask

  task automatic test_reset_exec();
    do_reset();
    press(4'd1); press(4'hA); press(4'd1); press(4'hF);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({disp_value, disp_op, flag_carry, flag_zero, result_valid, busy, err} !== 17'd0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_exec_outs: got %h state %0d want 0 0",
                         {disp_value, disp_op, flag_carry, flag_zero, result_valid, busy, err}, dbg_state);
    end
    n_checks++;
    if ({alu_if.cs, alu_if.a, alu_if.b, alu_if.carry_in} !== 21'd0) begin
      n_fail++; $display("FAIL reset_exec_alu: got %h want 0", {alu_if.cs, alu_if.a, alu_if.b, alu_if.carry_in});
    end
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_exec_dropped: got v %b state %0d want 0 0", result_valid, dbg_state);
    end
  endtask

  task automatic test_op_edit();
    do_reset();
    press(4'hA); press(4'hC);
    n_checks++;
    if (disp_op !== 4'hC) begin
      n_fail++; $display("FAIL op_replace: got %h want C", disp_op);
    end
    press(4'd3);
    n_checks++;
    if (disp_op !== 4'hC || disp_value !== 8'd3) begin
      n_fail++; $display("FAIL op_replace_b: got op %h disp %0d want C 3", disp_op, disp_value);
    end
    do_reset();
    press(4'hA); press(4'd3); press(4'hD);
    n_checks++;
    if (err !== 1'b1 || disp_op !== 4'hA) begin
      n_fail++; $display("FAIL op_locked: got err %b op %h want 1 A", err, disp_op);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    test_reset();
    test_add();
    test_chain_sub();
    test_overflow();
    test_cmp();
    test_busy();
    test_reset_exec();
    test_op_edit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
